// File: rtl/mem_access_unit_pkg.sv
// Shared CPU definitions for the memory-access stage: FSM encoding,
// default geometry constants and the latency helper.
`timescale 1ns/1ps
package mem_access_unit_pkg;

  localparam int DEFAULT_MEM_LATENCY = 3;
  localparam int DEFAULT_DEPTH_WORDS = 256;
  localparam int DATA_W              = 32;
  localparam int CNT_W               = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mau_state_e;

  // Counter value reached on the cycle an access completes.
  function automatic logic [CNT_W-1:0] last_cnt(input int latency);
    return CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/mem_access_unit_data_memory.sv
// Word-addressed data memory: synchronous write, combinational read.
// Contents are deliberately not reset.
`timescale 1ns/1ps
module mem_access_unit_data_memory
  import mem_access_unit_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_array [DEPTH_WORDS];

  // Commit a store on the rising edge when enabled.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_array[addr] <= wdata;
    end
  end

  assign rdata = mem_array[addr];

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: multi-cycle data-memory access FSM that freezes the
// upstream pipeline while an access is in flight, plus the MEM/WB register.
`timescale 1ns/1ps
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] RS2data_i,
  input  logic [4:0]  RDaddr_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALUResult_o,
  output logic [4:0]  RDaddr_o
);

  localparam int               IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = last_cnt(MEM_LATENCY);

  mau_state_e        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              req, read_only, done, mem_we;
  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] mem_rdata;

  // A request with both strobes set is a store only.
  assign req       = MemRead_i | MemWrite_i;
  assign read_only = MemRead_i & ~MemWrite_i;
  assign word_idx  = ALUResult_i[IDX_W+1:2];

  // State register: FSM state and access cycle counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state: keep counting while stalled; completion or a dropped
  // request (flush) returns to IDLE with the counter cleared.
  always_comb begin
    state_next = ST_IDLE;
    cnt_next   = '0;
    if (req && !done) begin
      state_next = ST_WAIT;
      cnt_next   = (state_reg == ST_IDLE) ? CNT_W'(1) : cnt_reg + CNT_W'(1);
    end
  end

  // Outputs: stall until the final access cycle; the store commits only on
  // the completion edge and never while reset is asserted.
  always_comb begin
    done    = 1'b0;
    stall_o = 1'b0;
    mem_we  = 1'b0;
    if (req) begin
      done    = (cnt_reg == CNT_LAST);
      stall_o = !done;
      mem_we  = done && MemWrite_i && rst_i;
    end
  end

  mem_access_unit_data_memory #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) data_memory (
    .clk_i (clk_i),
    .we    (mem_we),
    .addr  (word_idx),
    .wdata (RS2data_i),
    .rdata (mem_rdata)
  );

  // MEM/WB register: load on non-stalled edges, insert a bubble otherwise.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      RegWrite_o  <= 1'b0;
      MemtoReg_o  <= 1'b0;
      ReadData_o  <= '0;
      ALUResult_o <= '0;
      RDaddr_o    <= '0;
    end else if (stall_o) begin
      RegWrite_o  <= 1'b0;
      MemtoReg_o  <= 1'b0;
    end else begin
      RegWrite_o  <= RegWrite_i;
      MemtoReg_o  <= MemtoReg_i;
      ReadData_o  <= read_only ? mem_rdata : '0;
      ALUResult_o <= ALUResult_i;
      RDaddr_o    <= RDaddr_i;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: two instances (latency 3 / depth 256 and latency 1 /
// depth 16) driven instruction by instruction against a transaction-level
// model of memory contents and MEM/WB results.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        rw_i  [2];
  logic        mtr_i [2];
  logic        mr_i  [2];
  logic        mw_i  [2];
  logic [31:0] alu_i [2];
  logic [31:0] rs2_i [2];
  logic [4:0]  rd_i  [2];
  logic        stall_w [2];
  logic        rw_w    [2];
  logic        mtr_w   [2];
  logic [31:0] rdata_w [2];
  logic [31:0] alu_w   [2];
  logic [4:0]  rd_w    [2];

  // Reference model state
  logic [31:0] mem_model [2][256];
  int          lat   [2] = '{3, 1};
  int          depth [2] = '{256, 16};
  logic        exp_rw    [2];
  logic        exp_mtr   [2];
  logic [31:0] exp_rdata [2];
  logic [31:0] exp_alu   [2];
  logic [4:0]  exp_rd    [2];

  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit #(.MEM_LATENCY(3), .DEPTH_WORDS(256)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .RegWrite_i(rw_i[0]), .MemtoReg_i(mtr_i[0]), .MemRead_i(mr_i[0]), .MemWrite_i(mw_i[0]),
    .ALUResult_i(alu_i[0]), .RS2data_i(rs2_i[0]), .RDaddr_i(rd_i[0]),
    .stall_o(stall_w[0]), .RegWrite_o(rw_w[0]), .MemtoReg_o(mtr_w[0]),
    .ReadData_o(rdata_w[0]), .ALUResult_o(alu_w[0]), .RDaddr_o(rd_w[0])
  );

  mem_access_unit #(.MEM_LATENCY(1), .DEPTH_WORDS(16)) dut_lat1 (
    .clk_i(clk), .rst_i(rst_n),
    .RegWrite_i(rw_i[1]), .MemtoReg_i(mtr_i[1]), .MemRead_i(mr_i[1]), .MemWrite_i(mw_i[1]),
    .ALUResult_i(alu_i[1]), .RS2data_i(rs2_i[1]), .RDaddr_i(rd_i[1]),
    .stall_o(stall_w[1]), .RegWrite_o(rw_w[1]), .MemtoReg_o(mtr_w[1]),
    .ReadData_o(rdata_w[1]), .ALUResult_o(alu_w[1]), .RDaddr_o(rd_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic check_outputs(input int u, input string tag);
    check_val($sformatf("u%0d %s RegWrite_o", u, tag), 32'(rw_w[u]), 32'(exp_rw[u]));
    check_val($sformatf("u%0d %s MemtoReg_o", u, tag), 32'(mtr_w[u]), 32'(exp_mtr[u]));
    check_val($sformatf("u%0d %s ReadData_o", u, tag), rdata_w[u], exp_rdata[u]);
    check_val($sformatf("u%0d %s ALUResult_o", u, tag), alu_w[u], exp_alu[u]);
    check_val($sformatf("u%0d %s RDaddr_o", u, tag), 32'(rd_w[u]), 32'(exp_rd[u]));
  endtask

  task automatic clear_model_outputs(input int u);
    exp_rw[u] = 1'b0; exp_mtr[u] = 1'b0; exp_rdata[u] = '0; exp_alu[u] = '0; exp_rd[u] = '0;
  endtask

  // Present one instruction and hold it while the unit stalls, as the frozen
  // pipeline would. hold>0 and shorter than the access cuts it short (flush).
  task automatic do_instr(input int u, input logic rw, input logic mtr, input logic mr,
                          input logic mw, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rd, input int hold, input string name);
    int need, edges, idx;
    need  = (mr || mw) ? lat[u] : 1;
    edges = (hold > 0 && hold < need) ? hold : need;
    idx   = int'((addr >> 2) % 32'(depth[u]));
    $display("txn u%0d %-6s rw=%0b mtr=%0b mr=%0b mw=%0b addr=%08h data=%08h rd=%0d edges=%0d",
             u, name, rw, mtr, mr, mw, addr, data, rd, edges);
    for (int k = 0; k < edges; k++) begin
      @(negedge clk);
      rw_i[u] = rw; mtr_i[u] = mtr; mr_i[u] = mr; mw_i[u] = mw;
      alu_i[u] = addr; rs2_i[u] = data; rd_i[u] = rd;
      #1;
      check_val($sformatf("u%0d %s stall_o k=%0d", u, name, k), 32'(stall_w[u]), 32'(k < need - 1));
      @(posedge clk);
      #1;
      if (k < need - 1) begin
        exp_rw[u]  = 1'b0;
        exp_mtr[u] = 1'b0;
      end else begin
        if (mw) mem_model[u][idx] = data;
        exp_rw[u]    = rw;
        exp_mtr[u]   = mtr;
        exp_alu[u]   = addr;
        exp_rd[u]    = rd;
        exp_rdata[u] = (mr && !mw) ? mem_model[u][idx] : 32'h0;
      end
      check_outputs(u, name);
    end
  endtask

  // Park a unit on an all-zero no-op so it stays quiet while the other runs.
  task automatic park(input int u);
    do_instr(u, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 0, "park");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, d;
    int unsigned kind;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      rw_i[u] = 0; mtr_i[u] = 0; mr_i[u] = 0; mw_i[u] = 0;
      alu_i[u] = 0; rs2_i[u] = 0; rd_i[u] = 0;
      clear_model_outputs(u);
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check_val($sformatf("u%0d reset stall_o", u), 32'(stall_w[u]), 32'h0);
      check_outputs(u, "reset");
    end
    rst_n = 1'b1;

    // Give every word a known value so later loads are fully predictable.
    for (int i = 0; i < 256; i++)
      do_instr(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'(i * 4), $urandom, 5'd0, 0, "init");

    // Directed cases on the latency-3 unit
    do_instr(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 5'd0, 0, "sw");
    do_instr(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd7, 0, "lw");
    do_instr(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h24, 32'h0, 5'd5, 0, "lw_r5");
    do_instr(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd9, 0, "add");
    do_instr(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0BAD0BAD, 5'd0, 2, "flush");
    do_instr(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h77, 32'h0, 5'd3, 0, "nop");
    do_instr(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd4, 0, "lw");
    check_val("flush keeps word", rdata_w[0], mem_model[0][16]);

    // Reset in the middle of a store to 0x10
    do_instr(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'hA5A50001, 5'd0, 0, "sw");
    @(negedge clk);
    mw_i[0] = 1'b1; alu_i[0] = 32'h10; rs2_i[0] = 32'h11112222;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    mw_i[0] = 1'b0; alu_i[0] = '0; rs2_i[0] = '0;
    clear_model_outputs(0);
    clear_model_outputs(1);
    #1;
    $display("txn u0 reset  asserted during store wait");
    for (int u = 0; u < 2; u++) begin
      check_val($sformatf("u%0d async reset stall_o", u), 32'(stall_w[u]), 32'h0);
      check_outputs(u, "async_reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_instr(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd2, 0, "lw");
    check_val("reset keeps mem[4]", rdata_w[0], 32'hA5A50001);

    // Randomized instruction stream on the latency-3 unit
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 5);
      a = $urandom;
      d = $urandom;
      case (kind)
        0, 1: do_instr(0, 1'($urandom), 1'b0, 1'b0, 1'b0, a, d, 5'($urandom), 0, "alu");
        2:    do_instr(0, 1'b1, 1'b1, 1'b1, 1'b0, a, d, 5'($urandom), 0, "lw");
        3:    do_instr(0, 1'($urandom), 1'b0, 1'b0, 1'b1, a, d, 5'($urandom), 0, "sw");
        4:    do_instr(0, 1'($urandom), 1'($urandom), 1'b1, 1'b1, a, d, 5'($urandom), 0, "both");
        default: begin
          do_instr(0, 1'b0, 1'b0, 1'($urandom), 1'b1, a, d, 5'($urandom), 1 + int'($urandom_range(0, 1)), "flush");
          do_instr(0, 1'($urandom), 1'b0, 1'b0, 1'b0, d, a, 5'($urandom), 0, "alu");
        end
      endcase
    end
    park(0);

    // Latency-1 unit: no stalls at all, both strobes means store
    for (int i = 0; i < 16; i++)
      do_instr(1, 1'b0, 1'b0, 1'b0, 1'b1, 32'(i * 4), $urandom, 5'd0, 0, "init");
    do_instr(1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8, 32'h5, 5'd6, 0, "both");
    do_instr(1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 5'd6, 0, "lw");
    check_val("lat1 mem[2]", rdata_w[1], 32'h5);
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      a = $urandom;
      d = $urandom;
      case (kind)
        0:       do_instr(1, 1'($urandom), 1'b0, 1'b0, 1'b0, a, d, 5'($urandom), 0, "alu");
        1:       do_instr(1, 1'b1, 1'b1, 1'b1, 1'b0, a, d, 5'($urandom), 0, "lw");
        2:       do_instr(1, 1'b0, 1'b0, 1'b0, 1'b1, a, d, 5'($urandom), 0, "sw");
        default: do_instr(1, 1'($urandom), 1'($urandom), 1'b1, 1'b1, a, d, 5'($urandom), 0, "both");
      endcase
    end
    park(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
